// File: rtl/hilo_mul_div_unit.sv
// hilo_mul_div_unit
//   Execute-stage multi-cycle multiply/divide engine that owns the architectural
//   HI/LO pair and the MUL low-word result used by the GPR writeback path.
//   Build macro DIV_RADIX4_EN: when defined, the divider retires two quotient
//   bits per cycle (16 iterations) instead of one (32 iterations). Results are
//   identical in both builds; only the divide latency changes.
module hilo_mul_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic        flush,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_lo,
  output logic        done
);

`ifdef DIV_RADIX4_EN
  localparam int unsigned DIV_ITER = 16;
`else
  localparam int unsigned DIV_ITER = 32;
`endif
  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_ITER);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_lo_q, mul_lo_d;

  logic        is_mul_op;
  logic        is_div_op;
  logic        div_signed;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  logic        mul_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [63:0] acc;

  logic [31:0] step_rem;
  logic [31:0] step_quo;

  // Decode the incoming op and prepare divide operand magnitudes
  always_comb begin
    is_mul_op  = (op >= OP_MULT) && (op <= OP_MSUBU);
    is_div_op  = (op == OP_DIV) || (op == OP_DIVU);
    div_signed = (op == OP_DIV);
    rs_mag     = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
    rt_mag     = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
  end

  // 64-bit product of the latched operands; sign-extension selects signed vs unsigned
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MUL) ||
                 (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product    = a_ext * b_ext;
    acc        = {hi_q, lo_q};
  end

`ifdef DIV_RADIX4_EN
  logic [33:0] shifted4;
  logic [33:0] d1;
  logic [33:0] d2;
  logic [33:0] d3;

  // Radix-4 restoring step: pick the largest multiple of the divisor (0..3) that fits
  always_comb begin
    shifted4 = {rem_q, quo_q[31:30]};
    d1       = {2'b00, b_q};
    d2       = {1'b0, b_q, 1'b0};
    d3       = d1 + d2;
    if (shifted4 >= d3) begin
      step_rem = shifted4[31:0] - d3[31:0];
      step_quo = {quo_q[29:0], 2'b11};
    end else if (shifted4 >= d2) begin
      step_rem = shifted4[31:0] - d2[31:0];
      step_quo = {quo_q[29:0], 2'b10};
    end else if (shifted4 >= d1) begin
      step_rem = shifted4[31:0] - d1[31:0];
      step_quo = {quo_q[29:0], 2'b01};
    end else begin
      step_rem = shifted4[31:0];
      step_quo = {quo_q[29:0], 2'b00};
    end
  end
`else
  logic [32:0] shifted2;

  // Radix-2 restoring step: shift in one dividend bit and subtract the divisor if it fits
  always_comb begin
    shifted2 = {rem_q, quo_q[31]};
    if (shifted2 >= {1'b0, b_q}) begin
      step_rem = shifted2[31:0] - b_q;
      step_quo = {quo_q[30:0], 1'b1};
    end else begin
      step_rem = shifted2[31:0];
      step_quo = {quo_q[30:0], 1'b0};
    end
  end
`endif

  // Next-state and datapath update; flush overrides everything and leaves HI/LO alone
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_lo_d  = mul_lo_q;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            if (is_mul_op) begin
              state_d = ST_MUL;
              op_d    = op;
              a_d     = rs;
              b_d     = rt;
            end else if (is_div_op) begin
              state_d   = ST_DIV;
              op_d      = op;
              a_d       = rs;
              b_d       = rt_mag;
              quo_d     = rs_mag;
              rem_d     = 32'd0;
              neg_quo_d = div_signed && (rs[31] ^ rt[31]);
              neg_rem_d = div_signed && rs[31];
              cnt_d     = DIV_CNT_INIT;
            end else if (op == OP_MTHI) begin
              hi_d = rs;
            end else if (op == OP_MTLO) begin
              lo_d = rs;
            end
          end
        end

        ST_MUL: begin
          done    = 1'b1;
          state_d = ST_IDLE;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = product;
            OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + product;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - product;
            default:           mul_lo_d     = product[31:0];
          endcase
        end

        ST_DIV: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = ST_FIX;
          end
        end

        ST_FIX: begin
          done    = 1'b1;
          state_d = ST_IDLE;
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
            hi_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= 6'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mul_lo_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_lo_q  <= mul_lo_d;
    end
  end

  assign hi     = hi_q;
  assign lo     = lo_q;
  assign mul_lo = mul_lo_q;

endmodule
